// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised Fibonacci LFSR pseudo-random source with a
// valid/ready output stream, runtime seed loading and all-zero lockup recovery.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   en_i           run enable; state holds while low
//   seed_valid_i   load request for seed_i
//   seed_i         runtime seed (a zero seed loads SEED and flags lockup)
//   out_valid_o    random_value_o is valid (RUN and en_i)
//   out_ready_i    consumer accepts random_value_o
//   random_value_o current LFSR state
//   lockup_o       sticky: an all-zero state or seed was seen; cleared by rst_i
//
// Optional feature, macro LFSR_PERIOD_CNT_EN:
//   period_o       saturating step counter since the last load/reset/recovery
//   period_valid_o one-cycle strobe when an advance returns to the last seed
module lfsr_stream #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = 8'hAA,
  parameter int unsigned       STEPS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] random_value_o,
`ifdef LFSR_PERIOD_CNT_EN
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o,
`endif
  output logic             lockup_o
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_RECOVER
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_nlfsr;
  logic             r_lockup;
  logic             w_nlockup;
  logic [WIDTH-1:0] w_adv;
  logic             w_xfer;
  logic             w_load;
  logic             w_advance;

  // STEPS single-bit shifts unrolled into one combinational advance.
  always_comb begin
    logic [WIDTH-1:0] v;
    v = r_lfsr;
    for (int unsigned i = 0; i < STEPS; i++) begin
      v = {v[WIDTH-2:0], ^(v & TAPS)};
    end
    w_adv = v;
  end

  assign out_valid_o = (r_state == ST_RUN) && en_i;
  assign w_xfer      = out_valid_o && out_ready_i;
  // Seed loads are honoured in INIT and RUN (even with en_i low), never in RECOVER.
  assign w_load      = seed_valid_i && (r_state != ST_RECOVER);
  assign w_advance   = (r_state == ST_RUN) && w_xfer && !seed_valid_i;

  always_comb begin
    w_nstate  = r_state;
    w_nlfsr   = r_lfsr;
    w_nlockup = r_lockup;
    case (r_state)
      ST_INIT: begin
        w_nstate = ST_RUN;
      end
      ST_RUN: begin
        if (r_lfsr == '0) begin
          w_nstate = ST_RECOVER;
        end
        if (w_advance) begin
          w_nlfsr = w_adv;
        end
      end
      ST_RECOVER: begin
        w_nstate  = ST_RUN;
        w_nlfsr   = SEED;
        w_nlockup = 1'b1;
      end
      default: begin
        w_nstate = ST_INIT;
      end
    endcase
    if (w_load) begin
      if (seed_i == '0) begin
        w_nlfsr   = SEED;
        w_nlockup = 1'b1;
      end else begin
        w_nlfsr = seed_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_INIT;
      r_lfsr   <= SEED;
      r_lockup <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_lfsr   <= w_nlfsr;
      r_lockup <= w_nlockup;
    end
  end

  assign random_value_o = r_lfsr;
  assign lockup_o       = r_lockup;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_last_seed;
  logic             r_period_valid;
  logic             r_period_done;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_period} + (WIDTH+1)'(STEPS);

  // Once the period is found the counter freezes so period_o keeps the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_period       <= '0;
      r_last_seed    <= SEED;
      r_period_valid <= 1'b0;
      r_period_done  <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (r_state == ST_RECOVER) begin
        r_period      <= '0;
        r_last_seed   <= SEED;
        r_period_done <= 1'b0;
      end else if (w_load) begin
        r_period      <= '0;
        r_last_seed   <= w_nlfsr;
        r_period_done <= 1'b0;
      end else if (w_advance && !r_period_done) begin
        r_period <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        if (w_adv == r_last_seed) begin
          r_period_valid <= 1'b1;
          r_period_done  <= 1'b1;
        end
      end
    end
  end

  assign period_o       = r_period;
  assign period_valid_o = r_period_valid;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed, table-driven bench for lfsr_stream.
// Three instances: defaults, STEPS=2, and TAPS=0 (forces an all-zero state).
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, rdy, sv;
  logic [7:0] seed;
  logic       valid, lock;
  logic [7:0] value;

  logic       s2_valid, s2_lock;
  logic [7:0] s2_value;

  logic       t0_sv;
  logic [7:0] t0_seed;
  logic       t0_valid, t0_lock;
  logic [7:0] t0_value;

`ifdef LFSR_PERIOD_CNT_EN
  logic [7:0] period, s2_period, t0_period;
  logic       pvalid, s2_pvalid, t0_pvalid;
`endif

  always #5 clk = ~clk;

  lfsr_stream u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .seed_valid_i(sv), .seed_i(seed),
    .out_valid_o(valid), .out_ready_i(rdy), .random_value_o(value),
`ifdef LFSR_PERIOD_CNT_EN
    .period_o(period), .period_valid_o(pvalid),
`endif
    .lockup_o(lock)
  );

  lfsr_stream #(.STEPS(2)) u_s2 (
    .clk_i(clk), .rst_i(rst), .en_i(1'b1), .seed_valid_i(1'b0), .seed_i(8'h00),
    .out_valid_o(s2_valid), .out_ready_i(1'b1), .random_value_o(s2_value),
`ifdef LFSR_PERIOD_CNT_EN
    .period_o(s2_period), .period_valid_o(s2_pvalid),
`endif
    .lockup_o(s2_lock)
  );

  lfsr_stream #(.TAPS(8'h00)) u_t0 (
    .clk_i(clk), .rst_i(rst), .en_i(1'b1), .seed_valid_i(t0_sv), .seed_i(t0_seed),
    .out_valid_o(t0_valid), .out_ready_i(1'b1), .random_value_o(t0_value),
`ifdef LFSR_PERIOD_CNT_EN
    .period_o(t0_period), .period_valid_o(t0_pvalid),
`endif
    .lockup_o(t0_lock)
  );

  typedef struct {
    logic       en;
    logic       rdy;
    logic       sv;
    logic [7:0] seed;
    logic       valid;
    logic [7:0] value;
    logic       lock;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  logic [7:0] s2_exp [4];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial begin
    // Defaults: 0xAA -> 0x55 -> 0xAB -> 0x57 ; seed 0x3C -> 0x79 ; 0x81 -> 0x03
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hAA, 1'b0}; // INIT
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0}; // backpressure x5
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h57, 1'b0}; // load during transfer
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h79, 1'b0}; // en low holds
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h79, 1'b0}; // zero seed, en low
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 8'h55, 1'b1}; // load without transfer
    vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1};
    s2_exp[0] = 8'hAA; s2_exp[1] = 8'hAB; s2_exp[2] = 8'hAF; s2_exp[3] = 8'hBE;

    rst = 1'b1; en = 1'b1; rdy = 1'b1; sv = 1'b0; seed = 8'h00;
    t0_sv = 1'b0; t0_seed = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_value", value, 8'hAA);
    chk("reset_valid", valid, 1'b0);
    chk("reset_lock", lock, 1'b0);
`ifdef LFSR_PERIOD_CNT_EN
    chk("reset_period", period, 8'h00);
    chk("reset_pvalid", pvalid, 1'b0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      en = vecs[i].en; rdy = vecs[i].rdy; sv = vecs[i].sv; seed = vecs[i].seed;
      t0_sv   = (i == 0);
      t0_seed = (i == 0) ? 8'h01 : 8'h00;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), valid, vecs[i].valid);
      chk($sformatf("vec%0d_value", i), value, vecs[i].value);
      chk($sformatf("vec%0d_lock", i), lock, vecs[i].lock);
      if (i >= 1 && i <= 4) begin
        chk($sformatf("s2_row%0d_value", i), s2_value, s2_exp[i-1]);
        chk($sformatf("s2_row%0d_valid", i), s2_valid, 1'b1);
      end
      if (i >= 1 && i <= 8) chk($sformatf("t0_row%0d_value", i), t0_value, 8'h01 << (i - 1));
      if (i == 9) begin
        chk("t0_zero_value", t0_value, 8'h00);
        chk("t0_zero_valid", t0_valid, 1'b1);
        chk("t0_zero_lock", t0_lock, 1'b0);
      end
      if (i == 10) chk("t0_recover_valid", t0_valid, 1'b0);
      if (i == 11) begin
        chk("t0_after_recover_value", t0_value, 8'hAA);
        chk("t0_after_recover_valid", t0_valid, 1'b1);
        chk("t0_after_recover_lock", t0_lock, 1'b1);
      end
      if (i == 12) chk("t0_next_value", t0_value, 8'h54);
      if (i == 16) chk("t0_lock_sticky", t0_lock, 1'b1);
      @(posedge clk);
      #1;
    end

    // Mid-run reset overrides a concurrent seed load and transfer.
    rst = 1'b1; en = 1'b1; rdy = 1'b1; sv = 1'b1; seed = 8'h55;
    @(posedge clk);
    #1;
    rst = 1'b0; sv = 1'b0; seed = 8'h00;
    chk("midrst_value", value, 8'hAA);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_lock", lock, 1'b0);
    chk("midrst_t0_lock", t0_lock, 1'b0);
`ifdef LFSR_PERIOD_CNT_EN
    chk("midrst_period", period, 8'h00);
    chk("midrst_pvalid", pvalid, 1'b0);
    begin
      int pulses = 0;
      int pcyc   = -1;
      logic [7:0] pval = 8'h00;
      logic [7:0] pstate = 8'h00;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (pvalid) begin
          pulses++;
          if (pcyc < 0) begin
            pcyc = c; pval = period; pstate = value;
          end
        end
        @(posedge clk);
        #1;
      end
      chk("period_pulses", pulses, 1);
      chk("period_cycle", pcyc, 256);
      chk("period_count", pval, 8'hFF);
      chk("period_state", pstate, 8'hAA);
      chk("period_held", period, 8'hFF);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
- Parametrised Fibonacci LFSR pseudo-random source for the design's stimulus and noise generators; next generation of the fixed 8-bit LFSR.
- Width, tap mask, seed and number of shifts per cycle are all parameters.
- Adds a valid/ready output stream, a runtime seed-load port, and all-zero lockup detection with automatic recovery, controlled by a 3-state FSM.

Parameters:
- WIDTH, 8, register width in bits; legal range 3..32.
- TAPS, 8'hB8, feedback tap mask; bit i set means state[i] feeds the XOR.
- SEED, 8'hAA, reset and recovery value; must be non-zero.
- STEPS, 1, LFSR shifts per accepted output; legal range 1..WIDTH.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  run enable; when 0 the state holds.
- seed_valid_i  in  1  load request for seed_i.
- seed_i  in  WIDTH  runtime seed.
- out_valid_o  out  1  random_value_o is valid.
- out_ready_i  in  1  consumer accepts random_value_o.
- random_value_o  out  WIDTH  current LFSR state.
- lockup_o  out  1  sticky flag: an all-zero state or seed was seen; cleared only by rst_i.

Behaviour:
- One step: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Advance: apply the step STEPS times combinationally in one cycle; no added latency.
- Reset (rst_i=1): state=SEED, fsm=INIT, out_valid_o=0, lockup_o=0. Reset overrides every other input, including mid-stream.
- INIT:
  - Lasts one cycle with out_valid_o=0.
  - Always moves to RUN.
  - If seed_valid_i is high in INIT, the seed is loaded under the rules below, then the FSM goes to RUN.
- RUN:
  - out_valid_o = en_i.
  - Handshake: a transfer occurs when out_valid_o && out_ready_i.
  - On a transfer the state advances by STEPS shifts at the next edge.
  - Without a transfer, random_value_o is held stable.
- Seed load priority, in RUN:
  - seed_valid_i has priority over advance: state <= seed_i and there is no advance that cycle, even if a transfer occurs.
  - The transferred word is the pre-load value; the new seed appears the next cycle.
- Zero seed: if seed_i==0 on load, load SEED instead and set lockup_o.
- Lockup detection: if the state is all-zero in RUN (only reachable with a non-maximal TAPS), the FSM goes to RECOVER next cycle.
- RECOVER:
  - Lasts one cycle: out_valid_o=0, state <= SEED, lockup_o set, then the FSM returns to RUN.
  - seed_valid_i in RECOVER is ignored.
- en_i=0 in RUN: out_valid_o=0 and the state holds; seed loads are still honoured.
- Reset values: random_value_o=SEED, out_valid_o=0, lockup_o=0.

Optional Feature:
- Macro: LFSR_PERIOD_CNT_EN.
- With the macro defined, add two outputs:
  - period_o (WIDTH bits): the step counter.
  - period_valid_o (1 bit): the period-detected strobe.
- Counter operation:
  - The counter resets to 0 on rst_i, on a seed load, and in RECOVER.
  - It increments by STEPS per advance and saturates at all-ones.
- Period detection:
  - When an advance returns the state to the last loaded seed, period_valid_o pulses high for one cycle.
  - period_o then holds the count including that advance until the next load, reset or recovery.
- Without the macro, both ports and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then en_i=1, out_ready_i=1, defaults -> cycle after reset out_valid_o=0; successive transferred words 0xAA, 0x55, 0xAB, 0x57.
- Backpressure: out_ready_i=0 for 5 cycles while showing 0x55 -> random_value_o stays 0x55 with out_valid_o=1; after ready returns, the next word is 0xAB.
- STEPS=2, defaults -> transferred sequence 0xAA, 0xAB, ...
- Seed load with seed_i=0x3C during an active transfer -> transferred word is the old value, next word 0x3C. Zero seed load -> state 0xAA, lockup_o=1.
- TAPS=8'h00, seed 0x01 -> state reaches 0x00; the next cycle is RECOVER with out_valid_o=0; the following word is 0xAA; lockup_o stays 1 until rst_i.
- LFSR_PERIOD_CNT_EN defined, defaults, continuous transfers -> period_valid_o pulses exactly once after 255 advances with period_o=255. Mid-run rst_i -> all outputs return to their reset values the next cycle.
